// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: fetch FSM states, NOP encoding and instruction field positions shared with decode
package instruction_fetch_unit_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} ifu_state_e;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int FMT_HI = 25;
  localparam int FMT_LO = 21;
  localparam int FT_HI = 20;
  localparam int FT_LO = 16;
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: instruction memory req/ready fetch channel
interface instruction_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;
  modport master (output req, addr, input ready, rdata);
  modport slave (input req, addr, output ready, rdata);
endinterface

// File: rtl/instruction_fetch_unit_skid.sv
// ifu_skid_buffer: one-entry {valid, instr, pcplus4} store for a word fetched while decode is stalled
module ifu_skid_buffer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        drop_i,
  input  logic        pop_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pcp4_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pcp4_o
);
  logic        valid_q;
  logic [31:0] instr_q, pcp4_q;
  // entry becomes valid on load and empties on drop, pop or reset
  always_ff @(posedge clk) begin
    if (reset || drop_i || pop_i) valid_q <= 1'b0;
    else if (load_i) valid_q <= 1'b1;
    if (reset) begin
      instr_q <= '0;
      pcp4_q  <= '0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pcp4_q  <= pcp4_i;
    end
  end
  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pcp4_o  = pcp4_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: MIPS fetch stage (PC, imem handshake FSM, IF/ID register); IFU_PERF_CNT_EN adds perf counters
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             Stall,
  input  logic                             Flush,
  input  logic                             Redirect,
  input  logic [31:0]                      RedirectPC,
  instruction_fetch_unit_if.master         imem,
  output logic                             IFID_Valid,
  output logic [31:0]                      IFID_Instr,
  output logic [31:0]                      IFID_PCPlus4,
  output logic [5:0]                       OpCode,
  output logic [4:0]                       fmt,
  output logic [4:0]                       ft
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]                      perf_fetch_cnt,
  output logic [31:0]                      perf_bubble_cnt
`endif
);
  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d, pend_q, pend_d;
  logic        valid_q;
  logic [31:0] instr_q, pcp4_q;
  logic        req, load, skid_load, skid_drop, skid_pop, skid_valid;
  logic [31:0] load_instr, load_pcp4, skid_instr, skid_pcp4;

  ifu_skid_buffer u_skid (
    .clk     (clk),
    .reset   (reset),
    .load_i  (skid_load),
    .drop_i  (skid_drop),
    .pop_i   (skid_pop),
    .instr_i (imem.rdata),
    .pcp4_i  (pc_q + PC_STEP),
    .valid_o (skid_valid),
    .instr_o (skid_instr),
    .pcp4_o  (skid_pcp4)
  );

  // next state, next PC and what (if anything) the IF/ID register loads this cycle
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    req        = 1'b0;
    load       = 1'b0;
    skid_load  = 1'b0;
    skid_drop  = 1'b0;
    skid_pop   = 1'b0;
    load_instr = imem.rdata;
    load_pcp4  = pc_q + PC_STEP;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        req = 1'b1;
        if (imem.ready && Redirect) pc_d = RedirectPC;
        else if (imem.ready && Stall) begin
          skid_load = 1'b1;
          state_d   = HOLD;
        end else if (imem.ready) begin
          load = 1'b1;
          pc_d = pc_q + PC_STEP;
        end else if (Redirect) begin
          pend_d  = RedirectPC;
          state_d = DISCARD;
        end
      end
      HOLD: begin
        if (Redirect) begin
          skid_drop = 1'b1;
          pc_d      = RedirectPC;
          state_d   = FETCH;
        end else if (!Stall && skid_valid) begin
          skid_pop   = 1'b1;
          load       = 1'b1;
          load_instr = skid_instr;
          load_pcp4  = skid_pcp4;
          pc_d       = pc_q + PC_STEP;
          state_d    = FETCH;
        end
      end
      DISCARD: begin
        req = 1'b1;
        if (Redirect) pend_d = RedirectPC;
        if (imem.ready) begin
          pc_d    = Redirect ? RedirectPC : pend_q;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, PC and pending redirect target registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  // IF/ID register: Flush loads NOP, Stall holds, otherwise load a word or a bubble
  always_ff @(posedge clk) begin
    if (reset || Flush || (!Stall && !load)) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pcp4_q  <= '0;
    end else if (!Stall) begin
      valid_q <= 1'b1;
      instr_q <= load_instr;
      pcp4_q  <= load_pcp4;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;
  // count valid IF/ID loads and cycles that load a bubble or flush NOP
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (!Flush && !Stall && load) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (Flush || (!Stall && !load)) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end
  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`endif

  assign imem.req     = req;
  assign imem.addr    = pc_q;
  assign IFID_Valid   = valid_q;
  assign IFID_Instr   = instr_q;
  assign IFID_PCPlus4 = pcp4_q;
  assign OpCode       = instr_q[OPCODE_HI:OPCODE_LO];
  assign fmt          = instr_q[FMT_HI:FMT_LO];
  assign ft           = instr_q[FT_HI:FT_LO];
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed scoreboard bench for the fetch stage
module tb_instruction_fetch_unit;
  typedef struct {
    logic [31:0] pcp4;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1, stall = 1'b0, flush = 1'b0, redir = 1'b0, rst2 = 1'b1;
  logic [31:0] rpc = '0;
  logic        ifid_valid, v2;
  logic [31:0] ifid_instr, ifid_pcp4, i2, p2;
  logic [5:0]  opcode, op2;
  logic [4:0]  fmt, ft, fmt2, ft2;
  int          total = 0, bad = 0;
  exp_t        q[$];
`ifdef IFU_PERF_CNT_EN
  logic [31:0] pf, pb, pf2, pb2;
`endif

  instruction_fetch_unit_if bus ();
  instruction_fetch_unit_if bus2 ();

  instruction_fetch_unit u (
    .clk(clk), .reset(reset), .Stall(stall), .Flush(flush), .Redirect(redir), .RedirectPC(rpc),
    .imem(bus), .IFID_Valid(ifid_valid), .IFID_Instr(ifid_instr), .IFID_PCPlus4(ifid_pcp4),
    .OpCode(opcode), .fmt(fmt), .ft(ft)
`ifdef IFU_PERF_CNT_EN
    , .perf_fetch_cnt(pf), .perf_bubble_cnt(pb)
`endif
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u2 (
    .clk(clk), .reset(rst2), .Stall(1'b0), .Flush(1'b0), .Redirect(1'b0), .RedirectPC(32'h0),
    .imem(bus2), .IFID_Valid(v2), .IFID_Instr(i2), .IFID_PCPlus4(p2),
    .OpCode(op2), .fmt(fmt2), .ft(ft2)
`ifdef IFU_PERF_CNT_EN
    , .perf_fetch_cnt(pf2), .perf_bubble_cnt(pb2)
`endif
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    chk({tag, "_valid"}, {31'b0, ifid_valid}, 32'd1);
    if (q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s scoreboard_underflow observed=0 expected=1", tag);
    end else begin
      e = q.pop_front();
      chk({tag, "_instr"}, ifid_instr, e.instr);
      chk({tag, "_pcp4"}, ifid_pcp4, e.pcp4);
    end
  endtask

  initial begin
    bus.ready = 1'b0;
    bus.rdata = '0;
    bus2.ready = 1'b0;
    bus2.rdata = '0;
    step;
    step;
    chk("rst_req", {31'b0, bus.req}, 32'd0);
    chk("rst_valid", {31'b0, ifid_valid}, 32'd0);
    chk("rst_instr", ifid_instr, 32'h0);
    chk("rst_pcp4", ifid_pcp4, 32'h0);
    reset = 1'b0;
    chk("idle_req", {31'b0, bus.req}, 32'd0);
    step;
    chk("t1_req", {31'b0, bus.req}, 32'd1);
    chk("t1_addr0", bus.addr, 32'h0);
    bus.ready = 1'b1;
    bus.rdata = 32'h8C01_0004;
    q.push_back('{32'h4, 32'h8C01_0004});
    step;
    pop_chk("t1_w0");
    chk("t1_op0", {26'b0, opcode}, 32'h23);
    chk("t1_ft0", {27'b0, ft}, 32'h1);
    chk("t1_addr1", bus.addr, 32'h4);
    bus.rdata = 32'h0C00_0000;
    q.push_back('{32'h8, 32'h0C00_0000});
    step;
    pop_chk("t1_w1");
    chk("t1_op1", {26'b0, opcode}, 32'h03);
`ifdef IFU_PERF_CNT_EN
    chk("t1_perf_fetch", pf, 32'd2);
`endif
    bus.ready = 1'b0;
    reset = 1'b1;
    step;
    reset = 1'b0;
    step;
    for (int i = 0; i < 3; i++) begin
      chk("t2_addr", bus.addr, 32'h0);
      chk("t2_req", {31'b0, bus.req}, 32'd1);
      step;
      chk("t2_bubble", {31'b0, ifid_valid}, 32'd0);
    end
    chk("t2_addr_last", bus.addr, 32'h0);
    bus.ready = 1'b1;
    bus.rdata = 32'h2402_0007;
    q.push_back('{32'h4, 32'h2402_0007});
    step;
    pop_chk("t2_w");
    stall = 1'b1;
    bus.rdata = 32'h0043_0820;
    step;
    chk("t3_req_hold", {31'b0, bus.req}, 32'd0);
    chk("t3_instr_hold", ifid_instr, 32'h2402_0007);
    chk("t3_pcp4_hold", ifid_pcp4, 32'h4);
    bus.ready = 1'b0;
    bus.rdata = '0;
    step;
    chk("t3_req_hold2", {31'b0, bus.req}, 32'd0);
    chk("t3_valid_hold2", {31'b0, ifid_valid}, 32'd1);
    chk("t3_instr_hold2", ifid_instr, 32'h2402_0007);
    chk("t3_addr_hold2", bus.addr, 32'h4);
    stall = 1'b0;
    q.push_back('{32'h8, 32'h0043_0820});
    step;
    pop_chk("t3_skid");
    chk("t3_addr_next", bus.addr, 32'h8);
    chk("t3_req_next", {31'b0, bus.req}, 32'd1);
    bus.ready = 1'b1;
    bus.rdata = 32'h8C03_0008;
    q.push_back('{32'hC, 32'h8C03_0008});
    step;
    pop_chk("t4_w0");
    chk("t4_addrC", bus.addr, 32'hC);
    bus.rdata = 32'h46A4_0000;
    q.push_back('{32'h10, 32'h46A4_0000});
    step;
    pop_chk("t4_w1");
    chk("t4_op", {26'b0, opcode}, 32'h11);
    chk("t4_fmt", {27'b0, fmt}, 32'h15);
    chk("t4_ft", {27'b0, ft}, 32'h04);
    chk("t4_addr10", bus.addr, 32'h10);
    bus.ready = 1'b0;
    redir = 1'b1;
    flush = 1'b1;
    rpc = 32'h100;
    step;
    redir = 1'b0;
    flush = 1'b0;
    chk("t4_flush_valid", {31'b0, ifid_valid}, 32'd0);
    chk("t4_flush_instr", ifid_instr, 32'h0);
    chk("t4_disc_addr", bus.addr, 32'h10);
    chk("t4_disc_req", {31'b0, bus.req}, 32'd1);
    step;
    chk("t4_disc_addr2", bus.addr, 32'h10);
    bus.ready = 1'b1;
    bus.rdata = 32'hDEAD_BEEF;
    step;
    chk("t4_redir_addr", bus.addr, 32'h100);
    chk("t4_dropped", {31'b0, ifid_valid}, 32'd0);
    bus.rdata = 32'h1000_FFFF;
    q.push_back('{32'h104, 32'h1000_FFFF});
    step;
    pop_chk("t5_w");
    bus.ready = 1'b0;
    flush = 1'b1;
    stall = 1'b1;
    step;
    flush = 1'b0;
    stall = 1'b0;
    chk("t5_valid", {31'b0, ifid_valid}, 32'd0);
    chk("t5_instr", ifid_instr, 32'h0);
    chk("t5_pcp4", ifid_pcp4, 32'h0);
    rst2 = 1'b0;
    step;
    chk("t6_addr", bus2.addr, 32'hFFFF_FFFC);
    chk("t6_req", {31'b0, bus2.req}, 32'd1);
    bus2.ready = 1'b1;
    bus2.rdata = 32'h8C01_0004;
    step;
    bus2.ready = 1'b0;
    chk("t6_valid", {31'b0, v2}, 32'd1);
    chk("t6_instr", i2, 32'h8C01_0004);
    chk("t6_pcp4", p2, 32'h0);
    chk("t6_addr_wrap", bus2.addr, 32'h0);
`ifdef IFU_PERF_CNT_EN
    chk("t6_perf_fetch", pf2, 32'd1);
`endif
    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
